// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The wb_req data field matches the default 32-bit datapath (bit_size).
package reg_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0]  data;
   } wb_req;

   // Pointer width for an n-way round-robin; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback requester bus: per-requester valid/addr/data with a one-hot ready.
// Requester i occupies addr[5i+4:5i] and data slice i.
interface reg_wb_arbiter_if #(
   parameter int bit_size = 32,
   parameter int NUM_REQ  = 2
);
   import reg_wb_arbiter_pkg::*;

   logic [NUM_REQ-1:0]            req_valid;
   logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
   logic [bit_size*NUM_REQ-1:0]   req_data;
   logic [NUM_REQ-1:0]            req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer advances past
// the winner on each grant and holds otherwise. en_i low suppresses all grants.
module rr_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] gnt_o,
   output logic         gnt_any_o
);

   localparam int PTR_W = ptr_width(N);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] gnt_idx;
   int               idx;

   // Scan ptr, ptr+1, ... and take the first active requester.
   always_comb begin
      gnt_o     = '0;
      gnt_any_o = 1'b0;
      gnt_idx   = ptr_q;
      idx       = 0;
      if (en_i) begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!gnt_any_o && req_i[idx]) begin
               gnt_any_o    = 1'b1;
               gnt_o[idx]   = 1'b1;
               gnt_idx      = PTR_W'(idx);
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any_o) begin
         ptr_d = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant into a one-entry write stage,
// r0 writes dropped, read hazards, contention counter. Optional REG_WB_BYPASS_EN forwards the stage.
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int bit_size = 32,
   parameter int NUM_REQ  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_stall,
   reg_wb_arbiter_if.slave       bus,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] Write_reg,
   output logic [bit_size-1:0]   Write_data,
   input  logic [REG_ADDR_W-1:0] Read_reg1,
   input  logic [REG_ADDR_W-1:0] Read_reg2,
   input  logic [bit_size-1:0]   rf_data1,
   input  logic [bit_size-1:0]   rf_data2,
   output logic [bit_size-1:0]   Read_data1,
   output logic [bit_size-1:0]   Read_data2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic [CNT_W-1:0]      conflict_cnt
);

   logic [NUM_REQ-1:0]    gnt;
   logic                  gnt_any;
   logic [REG_ADDR_W-1:0] sel_addr;
   logic [bit_size-1:0]   sel_data;
   logic [NUM_REQ-1:0]    pend;

   logic       we_q;
   logic       we_d;
   wb_req      stage_q;
   wb_req      stage_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .clk       (clk),
      .rst       (rst),
      .en_i      (!wb_stall),
      .req_i     (bus.req_valid),
      .gnt_o     (gnt),
      .gnt_any_o (gnt_any)
   );

   assign bus.req_ready = gnt;

   always_comb begin
      sel_addr = REG_ZERO;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            sel_data = bus.req_data[i*bit_size +: bit_size];
         end
      end
   end

   // r0 grants are consumed like any other but never raise the write enable.
   always_comb begin
      we_d    = gnt_any && (sel_addr != REG_ZERO);
      stage_d = stage_q;
      if (gnt_any) begin
         stage_d.addr = sel_addr;
         stage_d.data = sel_data;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (($countones(bus.req_valid) >= 2) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         we_q    <= we_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   assign RegWrite     = we_q;
   assign Write_reg    = stage_q.addr;
   assign Write_data   = stage_q.data;
   assign conflict_cnt = cnt_q;

   // A read hazards on requests still waiting this cycle, not on the one being granted.
   always_comb begin
      pend    = bus.req_valid & ~gnt;
      hazard1 = 1'b0;
      hazard2 = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pend[i] && (Read_reg1 != REG_ZERO) &&
             (bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W] == Read_reg1)) begin
            hazard1 = 1'b1;
         end
         if (pend[i] && (Read_reg2 != REG_ZERO) &&
             (bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W] == Read_reg2)) begin
            hazard2 = 1'b1;
         end
      end
   end

`ifdef REG_WB_BYPASS_EN
   assign Read_data1 = (we_q && (stage_q.addr == Read_reg1)) ? stage_q.data : rf_data1;
   assign Read_data2 = (we_q && (stage_q.addr == Read_reg2)) ? stage_q.data : rf_data2;
`else
   assign Read_data1 = rf_data1;
   assign Read_data2 = rf_data2;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed steps plus random traffic against a queue-free
// reference model of grants, stage, register contents and contention count.
module tb_reg_wb_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_stall;
   logic          RegWrite;
   logic [4:0]    Write_reg;
   logic [DW-1:0] Write_data;
   logic [4:0]    Read_reg1, Read_reg2;
   logic [DW-1:0] rf_data1, rf_data2;
   logic [DW-1:0] Read_data1, Read_data2;
   logic          hazard1, hazard2;
   logic [15:0]   conflict_cnt;

   logic [N-1:0]  t_valid;
   logic [4:0]    t_addr [N];
   logic [DW-1:0] t_data [N];

   logic [DW-1:0] rf_mem [32];

   int            checks   = 0;
   int            failures = 0;

   int            m_ptr;
   bit            m_we;
   int            m_wreg;
   logic [DW-1:0] m_wdata;
   int            m_cnt;
   logic [DW-1:0] m_mem [32];

   reg_wb_arbiter_if #(.bit_size(DW), .NUM_REQ(N)) bus ();

   reg_wb_arbiter #(.bit_size(DW), .NUM_REQ(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_stall     (wb_stall),
      .bus          (bus),
      .RegWrite     (RegWrite),
      .Write_reg    (Write_reg),
      .Write_data   (Write_data),
      .Read_reg1    (Read_reg1),
      .Read_reg2    (Read_reg2),
      .rf_data1     (rf_data1),
      .rf_data2     (rf_data2),
      .Read_data1   (Read_data1),
      .Read_data2   (Read_data2),
      .hazard1      (hazard1),
      .hazard2      (hazard2),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   assign bus.req_valid = t_valid;
   always_comb begin
      bus.req_addr = '0;
      bus.req_data = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*5 +: 5]   = t_addr[i];
         bus.req_data[i*DW +: DW] = t_data[i];
      end
   end

   // Register file: commits at the clock edge ending the stage cycle, r0 hardwired.
   always @(posedge clk) begin
      if (RegWrite && (Write_reg != 5'd0)) rf_mem[Write_reg] <= Write_data;
   end
   assign rf_data1 = rf_mem[Read_reg1];
   assign rf_data2 = rf_mem[Read_reg2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_read(input logic [4:0] r);
`ifdef REG_WB_BYPASS_EN
      if (m_we && (m_wreg == int'(r))) return m_wdata;
`endif
      return m_mem[r];
   endfunction

   function automatic logic exp_hazard(input logic [4:0] r, input logic [N-1:0] rdy);
      if (r == 5'd0) return 1'b0;
      for (int i = 0; i < N; i++) begin
         if (t_valid[i] && !rdy[i] && (t_addr[i] == r)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_we    = 1'b0;
      m_wreg  = 0;
      m_wdata = '0;
      m_cnt   = 0;
   endtask

   // One clock cycle: check everything mid-cycle, then advance the model at the edge.
   task automatic step();
      int           g;
      int           idx;
      int           nv;
      logic [N-1:0] rdy;
      @(negedge clk);
      g = -1;
      if (!wb_stall) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if ((g < 0) && t_valid[idx]) g = idx;
         end
      end
      rdy = '0;
      if (g >= 0) rdy[g] = 1'b1;
      nv = 0;
      for (int i = 0; i < N; i++) nv += int'(t_valid[i]);
      chk("req_ready",    32'(bus.req_ready), 32'(rdy));
      chk("RegWrite",     32'(RegWrite),      32'(m_we));
      if (m_we) begin
         chk("Write_reg",  32'(Write_reg),  32'(m_wreg));
         chk("Write_data", Write_data,      m_wdata);
      end
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      chk("hazard1",      32'(hazard1),      32'(exp_hazard(Read_reg1, rdy)));
      chk("hazard2",      32'(hazard2),      32'(exp_hazard(Read_reg2, rdy)));
      chk("Read_data1",   Read_data1,        exp_read(Read_reg1));
      chk("Read_data2",   Read_data2,        exp_read(Read_reg2));
      @(posedge clk);
      if (m_we) m_mem[m_wreg] = m_wdata;
      if (g >= 0) begin
         m_ptr   = (g + 1) % N;
         m_we    = (t_addr[g] != 5'd0);
         m_wreg  = int'(t_addr[g]);
         m_wdata = t_data[g];
      end else begin
         m_we = 1'b0;
      end
      if ((nv >= 2) && (m_cnt < 65535)) m_cnt++;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = '0;
         m_mem[i]  = '0;
      end
      model_reset();
      rst       = 1'b1;
      wb_stall  = 1'b0;
      Read_reg1 = 5'd0;
      Read_reg2 = 5'd0;
      t_valid   = '1;
      t_addr[0] = 5'd1;  t_data[0] = 32'h1111_0001;
      t_addr[1] = 5'd2;  t_data[1] = 32'h2222_0002;

      // Reset held with every requester valid.
      repeat (3) begin
         @(negedge clk);
         chk("rst_RegWrite",     32'(RegWrite),     32'd0);
         chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
         chk("rst_Write_reg",    32'(Write_reg),    32'd0);
         chk("rst_Write_data",   Write_data,        32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      step();
      chk("first_grant_wreg", 32'(Write_reg), 32'd1);
      t_valid = 2'b10;
      step();

      // Round-robin between two continuously valid requesters.
      t_valid   = 2'b11;
      t_addr[0] = 5'd5;  t_data[0] = 32'hAAAA_0000;
      t_addr[1] = 5'd6;  t_data[1] = 32'h0000_BBBB;
      Read_reg1 = 5'd5;
      Read_reg2 = 5'd6;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_wreg", 32'(Write_reg), (i % 2 == 0) ? 32'd5 : 32'd6);
         chk("rr_we",   32'(RegWrite),  32'd1);
      end
      t_valid = '0;
      repeat (2) step();
      chk("rr_r5", Read_data1, 32'hAAAA_0000);
      chk("rr_r6", Read_data2, 32'h0000_BBBB);

      // Writes to r0 are consumed and dropped.
      t_valid   = 2'b01;
      t_addr[0] = 5'd0;  t_data[0] = 32'hFFFF_FFFF;
      Read_reg1 = 5'd0;
      step();
      chk("r0_we", 32'(RegWrite), 32'd0);
      t_valid = '0;
      repeat (2) step();
      chk("r0_read", Read_data1, 32'd0);

      // Stall with a pending r7 request.
      wb_stall  = 1'b1;
      t_valid   = 2'b10;
      t_addr[1] = 5'd7;  t_data[1] = 32'h0777_0777;
      Read_reg1 = 5'd7;
      repeat (3) step();
      wb_stall = 1'b0;
      step();
      chk("stall_release_wreg", 32'(Write_reg), 32'd7);
      t_valid = '0;
      step();

      // Bypass: old r9 value, then a new write read one and two cycles later.
      t_valid   = 2'b01;
      t_addr[0] = 5'd9;  t_data[0] = 32'h0BAD_F00D;
      step();
      t_valid = '0;
      repeat (2) step();
      Read_reg1 = 5'd9;
      t_valid   = 2'b01;
      t_data[0] = 32'h1234_5678;
      step();
      t_valid = '0;
`ifdef REG_WB_BYPASS_EN
      chk("bypass_t1", Read_data1, 32'h1234_5678);
`else
      chk("bypass_t1", Read_data1, 32'h0BAD_F00D);
`endif
      step();
      chk("bypass_t2", Read_data1, 32'h1234_5678);

      // Random traffic.
      for (int c = 0; c < 300; c++) begin
         t_valid   = N'($urandom);
         wb_stall  = ($urandom_range(0, 3) == 0);
         Read_reg1 = 5'($urandom_range(0, 15));
         Read_reg2 = 5'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            t_addr[i] = 5'($urandom_range(0, 15));
            t_data[i] = $urandom;
         end
         step();
      end

      // Asynchronous reset with a write sitting in the stage.
      wb_stall  = 1'b0;
      t_valid   = 2'b01;
      t_addr[0] = 5'd3;  t_data[0] = 32'h3333_3333;
      step();
      t_valid = '0;
      chk("pre_rst_we", 32'(RegWrite), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_we",   32'(RegWrite),     32'd0);
      chk("async_rst_cnt",  32'(conflict_cnt), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      Read_reg1 = 5'd3;
      step();
      t_valid = 2'b11;
      step();
      chk("post_rst_grant0", 32'(Write_reg), 32'd3);

      // Saturation of the contention counter.
      t_addr[0] = 5'd10;
      t_addr[1] = 5'd11;
      for (int c = 0; c < 65540; c++) begin
         t_data[0] = $urandom;
         t_data[1] = $urandom;
         wb_stall  = ($urandom_range(0, 7) == 0);
         step();
      end
      chk("cnt_saturated", 32'(conflict_cnt), 32'h0000_FFFF);
      step();
      chk("cnt_holds", 32'(conflict_cnt), 32'h0000_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and sequencer for the 32x32 register file. Shares the file's single write port (RegWrite/Write_reg/Write_data) among NUM_REQ writeback requesters (ALU result, load data, link address, …) using round-robin valid/ready arbitration. It registers the granted write into a one-entry output stage that drives the register file, and suppresses writes to register 0. It also reports per-read-port hazards and, optionally, bypasses the in-flight write to the read ports.

## Interface
- bit_size, 32: data width
- NUM_REQ, 2: number of requesters (2..4)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_stall  in  1  blocks new grants while high
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  5*NUM_REQ  destination register, requester i at [5i+4:5i]
- req_data  in  bit_size*NUM_REQ  write data, requester i at slice i
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
- RegWrite  out  1  register-file write enable (registered)
- Write_reg  out  5  register-file write address (registered)
- Write_data  out  bit_size  register-file write data (registered)
- Read_reg1, Read_reg2  in  5  read addresses, also sent to the register file
- rf_data1, rf_data2  in  bit_size  raw register-file read data
- Read_data1, Read_data2  out  bit_size  read data to the datapath
- hazard1, hazard2  out  1  read address matches a pending, non-granted request
- conflict_cnt  out  16  saturating count of cycles with ≥2 requests valid

## Operation
- Priority pointer ptr (log2 NUM_REQ bits) selects the highest-priority index. Grant goes to the first valid requester scanning ptr, ptr+1, … modulo NUM_REQ.
- req_ready is combinational and one-hot. It is all-zero when wb_stall=1 or no requester is valid. It never depends on req_data.
- On a grant to index g: ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Stage load on every edge:
  - RegWrite <= grant & (addr_g != 0).
  - Write_reg/Write_data <= requester g values on a grant, otherwise hold.
  - A request to register 0 is accepted (ready=1), consumed, and discarded.
- The stage never back-pressures; the register file accepts one write per cycle.
- Two requesters targeting the same register in one cycle: only one is granted. Order follows the round-robin order, so the later grant overwrites.
- hazardN = 1 when ReadN_reg != 0 and it matches req_addr of any requester with valid=1 and ready=0.
- conflict_cnt increments by 1 on any cycle with popcount(req_valid) ≥ 2. It saturates at 16'hFFFF.

## Timing
- Reset values: ptr=0, RegWrite=0, Write_reg=0, Write_data=0, conflict_cnt=0. req_ready is combinational and follows the inputs.
- Latency:
  - Grant in cycle t; stage valid in cycle t+1.
  - The register file commits at the end of cycle t+1.
  - Committed data is readable from the file in cycle t+2.
- Throughput: one write per cycle.
- A requester holding valid stays pending until granted. A single active requester is granted every cycle. With NUM_REQ requesters continuously valid, each is served every NUM_REQ cycles.
- wb_stall asserted in cycle t: no grant in t, and RegWrite=0 in t+1. ptr is unchanged.
- rst asserted mid-operation: the stage write is dropped immediately (RegWrite=0 asynchronously). Accepted-but-uncommitted data is lost, and ptr returns to 0.

## Configuration
- REG_WB_BYPASS_EN defined:
  - ReadN_data = Write_data when RegWrite=1 and Write_reg == ReadN_reg; otherwise rf_dataN.
  - This covers the cycle in which the stage write has not yet committed.
- Not defined: ReadN_data = rf_dataN, combinational pass-through. Reads in cycle t+1 return the old value.
- All other behaviour is identical in both builds.

## Structure
- Shared package holds:
  - REG_ADDR_W=5, REG_ZERO=5'd0
  - CNT_W=16
  - a wb_req typedef {addr, data}
- One sub-module, rr_arbiter (NUM_REQ-wide round-robin grant with pointer). It is reused later for other shared ports.
- The output stage, hazard compare, bypass mux and counter live in reg_wb_arbiter.

## Test plan
- Reset: rst=1 with all valids high, then release. Required: RegWrite=0 and conflict_cnt=0 during reset; the first grant after reset goes to requester 0.
- Round-robin: req0 writes r5=0xAAAA0000 and req1 writes r6=0x0000BBBB, both held valid continuously.
  - Required grants alternate 0,1,0,1.
  - RegWrite pulses every cycle.
  - After 2 cycles, r5 and r6 read back the written values.
  - conflict_cnt counts every cycle both are valid.
- Zero register: req0 writes r0=0xFFFFFFFF. Required: ready=1, RegWrite stays 0, r0 reads 0.
- Stall: wb_stall=1 for 3 cycles with req1 valid for r7. Required:
  - req_ready=0 and RegWrite=0 throughout the stall.
  - hazard1=1 when Read_reg1=7.
  - Grant occurs on the first unstalled cycle.
- Bypass: write r9=0x12345678, then read Read_reg1=9 in cycle t+1.
  - Built with REG_WB_BYPASS_EN: Read_data1=0x12345678.
  - Built without it: the old r9 value.
  - Both builds: the new value in t+2.
- Saturation: force conflict_cnt near 16'hFFFF (or run 65540 contended cycles). Required: it holds at 16'hFFFF.
